// File: rtl/fft_pkg.sv
// Shared FFT datapath types and sizing helpers.
package fft_pkg;

    localparam int NUM_LANES      = 16;
    localparam int FFT_DATA_WIDTH = 9;

    // One 16-lane row of signed samples; lane j is element [j].
    typedef logic signed [NUM_LANES-1:0][FFT_DATA_WIDTH-1:0] lane_row_t;

    // A complex row: real lanes then imaginary lanes.
    typedef struct packed {
        lane_row_t re;
        lane_row_t im;
    } cplx_row_t;

    // Output reorder sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PASS       = 2'd1,
        ST_DRAIN_PEND = 2'd2,
        ST_DRAIN      = 2'd3
    } reorder_state_t;

    // Rows in one delay-line phase.
    function automatic int phase_rows(input int mem_depth);
        return mem_depth / NUM_LANES;
    endfunction

    // Rows in one FFT frame.
    function automatic int frame_rows(input int frame_points);
        return frame_points / NUM_LANES;
    endfunction

    localparam int DEF_PHASE_LENGTH = phase_rows(128);
    localparam int DEF_FRAME_ROWS   = frame_rows(512);

endpackage

// File: rtl/row_fifo.sv
// Synchronous row FIFO with occupancy, full and empty flags.
module row_fifo #(
    parameter int WIDTH = 288,
    parameter int DEPTH = 16,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [OCC_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == OCC_W'(DEPTH));
    assign empty     = (count_r == {OCC_W{1'b0}});
    assign count     = count_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Row storage; contents are unobservable while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy tracks net push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {OCC_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + OCC_W'(1);
                2'b01:   count_r <= count_r - OCC_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bfly_out_reorder.sv
// Re-serialises butterfly sum/diff row pairs into one SDF-ordered stream:
// sums pass through registered, diffs are buffered and replayed in the gaps.
module bfly_out_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH   = 9,
    parameter int MEM_DEPTH    = 128,
    parameter int FRAME_POINTS = 512
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        bfly_valid,
    input  logic signed [NUM_LANES-1:0][DATA_WIDTH-1:0] sum_re,
    input  logic signed [NUM_LANES-1:0][DATA_WIDTH-1:0] sum_im,
    input  logic signed [NUM_LANES-1:0][DATA_WIDTH-1:0] diff_re,
    input  logic signed [NUM_LANES-1:0][DATA_WIDTH-1:0] diff_im,
    output logic signed [NUM_LANES-1:0][DATA_WIDTH-1:0] dout_re,
    output logic signed [NUM_LANES-1:0][DATA_WIDTH-1:0] dout_im,
    output logic                                        dout_valid,
    output logic                                        frame_done,
    output logic                                        overflow
);

    localparam int PL        = phase_rows(MEM_DEPTH);
    localparam int FR        = frame_rows(FRAME_POINTS);
    localparam int FIFO_ROWS = 2 * PL;
    localparam int HALF_W    = NUM_LANES * DATA_WIDTH;
    localparam int ROW_W     = 2 * HALF_W;
    localparam int OCC_W     = $clog2(FIFO_ROWS + 1);
    localparam int CNT_W     = $clog2(PL + 1);
    localparam int FRM_W     = (FR > 1) ? $clog2(FR) : 1;

    reorder_state_t   state_r;
    reorder_state_t   state_nxt_s;
    logic [CNT_W-1:0] pass_cnt_r;
    logic [CNT_W-1:0] pass_cnt_nxt_s;
    logic [CNT_W-1:0] drain_cnt_r;
    logic [CNT_W-1:0] drain_cnt_nxt_s;
    logic [CNT_W-1:0] drain_cnt_inc_s;
    logic [FRM_W-1:0] frame_cnt_r;
    logic [OCC_W-1:0] occ_s;
    logic [ROW_W-1:0] rd_row_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;

    // Sums always win; a diff is dropped only when the buffer is full.
    assign push_s = bfly_valid & ~full_s;
    assign drop_s = bfly_valid & full_s;
    assign pop_s  = ~bfly_valid & ~empty_s &
                    ((state_r == ST_DRAIN_PEND) || (state_r == ST_DRAIN));

    row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_ROWS),
        .OCC_W (OCC_W)
    ) u_diff_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({diff_re, diff_im}),
        .rdata (rd_row_s),
        .count (occ_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Sequencing state and phase counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            pass_cnt_r  <= {CNT_W{1'b0}};
            drain_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            pass_cnt_r  <= pass_cnt_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

    // Next state: count a phase of sums, then drain; a drain that empties the buffer ends it.
    always_comb begin
        state_nxt_s     = state_r;
        pass_cnt_nxt_s  = pass_cnt_r;
        drain_cnt_nxt_s = drain_cnt_r;
        drain_cnt_inc_s = (state_r == ST_DRAIN) ? drain_cnt_r + CNT_W'(1) : CNT_W'(1);
        case (state_r)
            ST_IDLE, ST_PASS: begin
                if (bfly_valid) begin
                    if (pass_cnt_r == CNT_W'(PL - 1)) begin
                        state_nxt_s    = ST_DRAIN_PEND;
                        pass_cnt_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s    = ST_PASS;
                        pass_cnt_nxt_s = pass_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN_PEND, ST_DRAIN: begin
                if (bfly_valid) begin
                    state_nxt_s = state_r;
                end else if (pop_s) begin
                    if (occ_s == OCC_W'(1)) begin
                        state_nxt_s     = ST_IDLE;
                        drain_cnt_nxt_s = {CNT_W{1'b0}};
                    end else if (drain_cnt_inc_s == CNT_W'(PL)) begin
                        state_nxt_s     = ST_DRAIN_PEND;
                        drain_cnt_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s     = ST_DRAIN;
                        drain_cnt_nxt_s = drain_cnt_inc_s;
                    end
                end else begin
                    state_nxt_s     = ST_IDLE;
                    drain_cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                pass_cnt_nxt_s  = {CNT_W{1'b0}};
                drain_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Registered output row mux, sticky overflow and frame row counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_re     <= {HALF_W{1'b0}};
            dout_im     <= {HALF_W{1'b0}};
            dout_valid  <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            frame_cnt_r <= {FRM_W{1'b0}};
        end else begin
            overflow <= overflow | drop_s;
            if (bfly_valid) begin
                dout_re    <= sum_re;
                dout_im    <= sum_im;
                dout_valid <= 1'b1;
            end else if (pop_s) begin
                dout_re    <= rd_row_s[ROW_W-1:HALF_W];
                dout_im    <= rd_row_s[HALF_W-1:0];
                dout_valid <= 1'b1;
            end else begin
                dout_valid <= 1'b0;
            end
            if (bfly_valid || pop_s) begin
                if (frame_cnt_r == FRM_W'(FR - 1)) begin
                    frame_cnt_r <= {FRM_W{1'b0}};
                    frame_done  <= 1'b1;
                end else begin
                    frame_cnt_r <= frame_cnt_r + FRM_W'(1);
                    frame_done  <= 1'b0;
                end
            end else begin
                frame_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bfly_out_reorder.sv
// Directed + randomised bench for bfly_out_reorder with a queue-based reference model.
module tb_bfly_out_reorder;
    import fft_pkg::*;

    localparam int DW        = FFT_DATA_WIDTH;
    localparam int PL        = DEF_PHASE_LENGTH;
    localparam int FR        = DEF_FRAME_ROWS;
    localparam int FIFO_ROWS = 2 * PL;
    localparam int ROW_W     = 2 * NUM_LANES * DW;

    logic      clk = 1'b0;
    logic      rstn;
    logic      bfly_valid;
    lane_row_t sum_re, sum_im, diff_re, diff_im, dout_re, dout_im;
    logic      dout_valid, frame_done, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of pending diffs, drain armed once a phase of sums is in.
    cplx_row_t m_q[$];
    bit        m_armed;
    int        m_sum_cnt;
    cplx_row_t m_row;
    bit        m_valid, m_fd, m_ovf;
    int        m_frame;

    cplx_row_t cap[$];
    int        cap_fd_idx[$];
    int        out_idx;
    cplx_row_t sq[$];
    cplx_row_t dq[$];
    cplx_row_t exp_q[$];
    cplx_row_t zero_row;

    always #5 clk = ~clk;

    bfly_out_reorder #(
        .DATA_WIDTH   (DW),
        .MEM_DEPTH    (128),
        .FRAME_POINTS (512)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bfly_valid (bfly_valid),
        .sum_re     (sum_re),
        .sum_im     (sum_im),
        .diff_re    (diff_re),
        .diff_im    (diff_im),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_armed   = 1'b0;
        m_sum_cnt = 0;
        m_row     = '0;
        m_valid   = 1'b0;
        m_fd      = 1'b0;
        m_ovf     = 1'b0;
        m_frame   = 0;
    endtask

    task automatic model_step(input logic v, input cplx_row_t s, input cplx_row_t d);
        if (v) begin
            m_row   = s;
            m_valid = 1'b1;
            if (m_q.size() < FIFO_ROWS) m_q.push_back(d);
            else m_ovf = 1'b1;
            if (!m_armed) begin
                m_sum_cnt++;
                if (m_sum_cnt == PL) begin
                    m_armed   = 1'b1;
                    m_sum_cnt = 0;
                end
            end
        end else if (m_armed && m_q.size() > 0) begin
            m_row   = m_q.pop_front();
            m_valid = 1'b1;
            if (m_q.size() == 0) m_armed = 1'b0;
        end else begin
            m_valid = 1'b0;
        end
        if (m_valid) begin
            m_fd    = (m_frame == FR - 1);
            m_frame = (m_frame == FR - 1) ? 0 : m_frame + 1;
        end else begin
            m_fd = 1'b0;
        end
    endtask

    task automatic cycle(input logic v, input cplx_row_t s, input cplx_row_t d);
        bfly_valid = v;
        sum_re  = s.re;
        sum_im  = s.im;
        diff_re = d.re;
        diff_im = d.im;
        if (v) begin
            sq.push_back(s);
            dq.push_back(d);
        end
        model_step(v, s, d);
        @(posedge clk);
        #1;
        if (dout_valid === 1'b1) begin
            cap.push_back(cplx_row_t'({dout_re, dout_im}));
            if (frame_done === 1'b1) cap_fd_idx.push_back(out_idx);
            out_idx++;
        end
        chk("dout_valid", ROW_W'(dout_valid), ROW_W'(m_valid));
        chk("frame_done", ROW_W'(frame_done), ROW_W'(m_fd));
        chk("overflow",   ROW_W'(overflow),   ROW_W'(m_ovf));
        chk("dout_row",   {dout_re, dout_im}, m_row);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, zero_row, zero_row);
    endtask

    function automatic cplx_row_t rand_row();
        cplx_row_t r;
        for (int j = 0; j < NUM_LANES; j++) begin
            r.re[j] = DW'($urandom);
            r.im[j] = DW'($urandom);
        end
        return r;
    endfunction

    // Test-plan row: re lanes = +/-(100+k), im lanes = +/-(16k+j) to expose lane order.
    function automatic cplx_row_t plan_row(input int k, input bit neg);
        cplx_row_t r;
        for (int j = 0; j < NUM_LANES; j++) begin
            r.re[j] = neg ? DW'(-(100 + k)) : DW'(100 + k);
            r.im[j] = neg ? DW'(-(16 * k + j)) : DW'(16 * k + j);
        end
        return r;
    endfunction

    task automatic apply_reset();
        bfly_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_dout_valid", ROW_W'(dout_valid), ROW_W'(1'b0));
        chk("rst_frame_done", ROW_W'(frame_done), ROW_W'(1'b0));
        chk("rst_overflow",   ROW_W'(overflow),   ROW_W'(1'b0));
        chk("rst_dout_row",   {dout_re, dout_im}, {ROW_W{1'b0}});
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cap.delete();
        cap_fd_idx.delete();
        sq.delete();
        dq.delete();
        exp_q.delete();
        out_idx = 0;
    endtask

    task automatic cmp_cap(input string tag);
        chk({tag, "_rows"}, ROW_W'(cap.size()), ROW_W'(exp_q.size()));
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_row%0d", tag, i), cap[i], exp_q[i]);
    endtask

    task automatic plan_block();
        for (int k = 0; k < PL; k++) cycle(1'b1, plan_row(k, 1'b0), plan_row(k, 1'b1));
        idle(PL + 2);
        exp_q.delete();
        for (int k = 0; k < PL; k++) exp_q.push_back(plan_row(k, 1'b0));
        for (int k = 0; k < PL; k++) exp_q.push_back(plan_row(k, 1'b1));
        cmp_cap("plan");
    endtask

    initial begin
        zero_row   = '0;
        rstn       = 1'b1;
        bfly_valid = 1'b0;
        sum_re = '0; sum_im = '0; diff_re = '0; diff_im = '0;
        #2;

        // Reset state, then one 8-row block with recognisable values.
        apply_reset();
        plan_block();

        // Full frame: 4 blocks of 8 random rows each followed by 8 gap cycles.
        apply_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < PL; k++) cycle(1'b1, rand_row(), rand_row());
            idle(PL);
        end
        chk("frame_rows", ROW_W'(cap.size()), ROW_W'(64));
        chk("frame_pulses", ROW_W'(cap_fd_idx.size()), ROW_W'(2));
        if (cap_fd_idx.size() > 0) chk("frame_first_idx", ROW_W'(cap_fd_idx[0]), ROW_W'(FR - 1));
        chk("frame_no_ovf", ROW_W'(overflow), ROW_W'(1'b0));

        // Back-to-back: two blocks with no gap.
        apply_reset();
        for (int k = 0; k < 2 * PL; k++) cycle(1'b1, rand_row(), rand_row());
        idle(2 * PL);
        for (int k = 0; k < 2 * PL; k++) exp_q.push_back(sq[k]);
        for (int k = 0; k < 2 * PL; k++) exp_q.push_back(dq[k]);
        cmp_cap("b2b");
        chk("b2b_no_ovf", ROW_W'(overflow), ROW_W'(1'b0));

        // Drain pause: 8 rows, 3 idle, 1 row, 10 idle.
        apply_reset();
        for (int k = 0; k < PL; k++) cycle(1'b1, rand_row(), rand_row());
        idle(3);
        cycle(1'b1, rand_row(), rand_row());
        idle(10);
        for (int k = 0; k < 8; k++) exp_q.push_back(sq[k]);
        for (int k = 0; k < 3; k++) exp_q.push_back(dq[k]);
        exp_q.push_back(sq[8]);
        for (int k = 3; k < 9; k++) exp_q.push_back(dq[k]);
        cmp_cap("pause");

        // Overflow: 24 contiguous rows, diffs 16..23 dropped.
        apply_reset();
        for (int k = 0; k < 24; k++) cycle(1'b1, rand_row(), rand_row());
        idle(20);
        for (int k = 0; k < 24; k++) exp_q.push_back(sq[k]);
        for (int k = 0; k < 16; k++) exp_q.push_back(dq[k]);
        cmp_cap("ovf");
        chk("ovf_sticky", ROW_W'(overflow), ROW_W'(1'b1));

        // Reset after 3 diffs have drained, then a fresh block.
        apply_reset();
        for (int k = 0; k < PL; k++) cycle(1'b1, plan_row(k, 1'b0), plan_row(k, 1'b1));
        idle(3);
        apply_reset();
        plan_block();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
